// File: rtl/bcd2_scan_display.sv
// Two-digit multiplexed common-anode 7-segment driver fed by a packed BCD shadow register.
// Optional build macro LEADING_ZERO_BLANK_EN darkens the tens digit when it is zero.
module bcd2_scan_display #(
    parameter int unsigned SCAN_DIV    = 50000,
    parameter int unsigned DEAD_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] bcd_in,
    input  logic       load,
    input  logic [1:0] dp_in,
    output logic [6:0] seg,
    output logic       dp,
    output logic [1:0] an,
    output logic       err
);

    localparam int unsigned MAX_LEN = (SCAN_DIV > DEAD_CYCLES)
        ? ((SCAN_DIV > 2) ? SCAN_DIV : 2)
        : ((DEAD_CYCLES > 2) ? DEAD_CYCLES : 2);
    localparam int unsigned CW = $clog2(MAX_LEN);
    localparam logic [CW-1:0] SHOW_LAST = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] DEAD_LAST = CW'((DEAD_CYCLES > 0) ? (DEAD_CYCLES - 1) : 0);

    typedef enum logic [1:0] {StShowLo, StDeadA, StShowHi, StDeadB} state_e;

    state_e        state_q, state_nxt;
    logic [CW-1:0] cnt_q, slot_last;
    logic [7:0]    shadow_bcd_q;
    logic [1:0]    shadow_dp_q;
    logic [6:0]    seg_q, seg_d;
    logic          dp_q, dp_d;
    logic [1:0]    an_q, an_d;
    logic          err_q, bcd_bad;

    function automatic logic [6:0] decode(input logic [3:0] d);
        case (d)
            4'd0:    decode = 7'h40;
            4'd1:    decode = 7'h79;
            4'd2:    decode = 7'h24;
            4'd3:    decode = 7'h30;
            4'd4:    decode = 7'h19;
            4'd5:    decode = 7'h12;
            4'd6:    decode = 7'h02;
            4'd7:    decode = 7'h78;
            4'd8:    decode = 7'h00;
            4'd9:    decode = 7'h10;
            default: decode = 7'h3F;
        endcase
    endfunction

    assign bcd_bad = (shadow_bcd_q[3:0] > 4'd9) || (shadow_bcd_q[7:4] > 4'd9);

    always_comb begin
        slot_last = ((state_q == StShowLo) || (state_q == StShowHi)) ? SHOW_LAST : DEAD_LAST;
        state_nxt = StShowLo;
        unique case (state_q)
            StShowLo: state_nxt = (DEAD_CYCLES == 0) ? StShowHi : StDeadA;
            StDeadA:  state_nxt = StShowHi;
            StShowHi: state_nxt = (DEAD_CYCLES == 0) ? StShowLo : StDeadB;
            StDeadB:  state_nxt = StShowLo;
            default:  state_nxt = StShowLo;
        endcase
    end

    always_comb begin
        seg_d = 7'h7F;
        dp_d  = 1'b1;
        an_d  = 2'b11;
        unique case (state_q)
            StShowLo: begin
                an_d  = 2'b10;
                seg_d = decode(shadow_bcd_q[3:0]);
                dp_d  = ~shadow_dp_q[0];
            end
            StShowHi: begin
`ifdef LEADING_ZERO_BLANK_EN
                if (shadow_bcd_q[7:4] != 4'd0) begin
                    an_d  = 2'b01;
                    seg_d = decode(shadow_bcd_q[7:4]);
                    dp_d  = ~shadow_dp_q[1];
                end
`else
                an_d  = 2'b01;
                seg_d = decode(shadow_bcd_q[7:4]);
                dp_d  = ~shadow_dp_q[1];
`endif
            end
            default: ;
        endcase
    end

    // Outputs are decoded from the pre-edge state/shadow, so they lag the FSM by one cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            shadow_bcd_q <= 8'h00;
            shadow_dp_q  <= 2'b00;
            state_q      <= StShowLo;
            cnt_q        <= '0;
            seg_q        <= 7'h7F;
            dp_q         <= 1'b1;
            an_q         <= 2'b11;
            err_q        <= 1'b0;
        end else begin
            if (load) begin
                shadow_bcd_q <= bcd_in;
                shadow_dp_q  <= dp_in;
            end
            err_q <= err_q | bcd_bad;
            seg_q <= seg_d;
            dp_q  <= dp_d;
            an_q  <= an_d;
            if (cnt_q == slot_last) begin
                cnt_q   <= '0;
                state_q <= state_nxt;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign seg = seg_q;
    assign dp  = dp_q;
    assign an  = an_q;
    assign err = err_q;

endmodule

// File: tb/tb_bcd2_scan_display.sv
// Directed bench for bcd2_scan_display with SCAN_DIV=4, DEAD_CYCLES=1 (10-cycle scan period).
module tb_bcd2_scan_display;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] bcd_in;
    logic       load;
    logic [1:0] dp_in;
    logic [6:0] seg;
    logic       dp;
    logic [1:0] an;
    logic       err;

    int total = 0;
    int bad   = 0;

    bcd2_scan_display #(
        .SCAN_DIV   (4),
        .DEAD_CYCLES(1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bcd_in(bcd_in),
        .load  (load),
        .dp_in (dp_in),
        .seg   (seg),
        .dp    (dp),
        .an    (an),
        .err   (err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [1:0] e_an, input logic [6:0] e_seg,
                           input logic e_dp);
        chk({tag, ".an"}, {6'd0, an}, {6'd0, e_an});
        chk({tag, ".seg"}, {1'b0, seg}, {1'b0, e_seg});
        chk({tag, ".dp"}, {7'd0, dp}, {7'd0, e_dp});
    endtask

    // Ten edges starting at the first units edge of a scan period.
    task automatic check_period(input string tag, input logic [6:0] s_lo, input logic d_lo,
                                input logic [6:0] s_hi, input logic d_hi);
        for (int i = 0; i < 10; i++) begin
            tick();
            if (i < 4)                chk_out(tag, 2'b10, s_lo, d_lo);
            else if (i == 4 || i == 9) chk_out(tag, 2'b11, 7'h7F, 1'b1);
            else                      chk_out(tag, 2'b01, s_hi, d_hi);
        end
    endtask

    initial begin
        reset  = 1'b1;
        load   = 1'b1;
        bcd_in = 8'h37;
        dp_in  = 2'b00;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_out("reset", 2'b11, 7'h7F, 1'b1);
            chk("reset.err", {7'd0, err}, 8'd0);
        end
        reset = 1'b0;
        load  = 1'b0;

        // e1: shadow must still be 00 despite load during reset
        tick();
        chk_out("post_reset_units", 2'b10, 7'h40, 1'b1);
        load   = 1'b1;
        bcd_in = 8'h37;
        dp_in  = 2'b01;
        tick(); // e2: load captured; output still from old shadow
        chk_out("load_edge_old", 2'b10, 7'h40, 1'b1);
        load = 1'b0;
        tick(); // e3
        chk_out("scan_lo_a", 2'b10, 7'h78, 1'b0);
        tick(); // e4
        chk_out("scan_lo_b", 2'b10, 7'h78, 1'b0);
        tick(); // e5
        chk_out("dead_a", 2'b11, 7'h7F, 1'b1);
        for (int i = 0; i < 4; i++) begin
            tick(); // e6..e9
            chk_out("scan_hi", 2'b01, 7'h30, 1'b1);
        end
        tick(); // e10
        chk_out("dead_b", 2'b11, 7'h7F, 1'b1);
        check_period("period1", 7'h78, 1'b0, 7'h30, 1'b1); // e11..e20
        check_period("period2", 7'h78, 1'b0, 7'h30, 1'b1); // e21..e30 pre-check

        // Invalid BCD 5A loaded at e31
        load   = 1'b1;
        bcd_in = 8'h5A;
        dp_in  = 2'b00;
        tick(); // e31
        chk("err_before", {7'd0, err}, 8'd0);
        chk_out("inv_load_edge", 2'b10, 7'h78, 1'b0);
        load = 1'b0;
        tick(); // e32
        chk("err_set", {7'd0, err}, 8'd1);
        chk_out("inv_units", 2'b10, 7'h3F, 1'b1);
        tick(); tick(); tick(); // e33..e35
        chk_out("inv_dead", 2'b11, 7'h7F, 1'b1);
        tick(); // e36
        chk_out("inv_tens", 2'b01, 7'h12, 1'b1);
        tick(); tick(); tick(); tick(); // e37..e40
        chk_out("inv_dead_b", 2'b11, 7'h7F, 1'b1);
        load   = 1'b1;
        bcd_in = 8'h00;
        tick(); // e41
        load = 1'b0;
        tick(); // e42
        chk("err_sticky", {7'd0, err}, 8'd1);
        chk_out("zero_units", 2'b10, 7'h40, 1'b1);

        // Reload 37 and do a load during the 2nd cycle of SHOW_HI
        load   = 1'b1;
        bcd_in = 8'h37;
        tick(); // e43
        load = 1'b0;
        tick(); // e44
        chk_out("reload_units", 2'b10, 7'h78, 1'b1);
        tick(); // e45
        chk_out("mid_dead_a", 2'b11, 7'h7F, 1'b1);
        tick(); // e46
        chk_out("mid_hi1", 2'b01, 7'h30, 1'b1);
        load   = 1'b1;
        bcd_in = 8'h59;
        tick(); // e47: captured, still old value
        chk_out("mid_hi2", 2'b01, 7'h30, 1'b1);
        load = 1'b0;
        tick(); // e48
        chk_out("mid_hi3", 2'b01, 7'h12, 1'b1);
        tick(); // e49
        chk_out("mid_hi4", 2'b01, 7'h12, 1'b1);
        tick(); // e50
        chk_out("mid_slot_end", 2'b11, 7'h7F, 1'b1);
        tick(); // e51
        chk_out("new_units", 2'b10, 7'h10, 1'b1);
        tick(); tick(); tick(); tick(); // e52..e55
        tick(); // e56
        chk_out("pre_reset_hi", 2'b01, 7'h12, 1'b1);

        // Reset mid-scan
        reset = 1'b1;
        tick();
        chk_out("mid_reset", 2'b11, 7'h7F, 1'b1);
        chk("mid_reset.err", {7'd0, err}, 8'd0);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick(); // f1..f4
            chk_out("restart_units", 2'b10, 7'h40, 1'b1);
        end
        tick(); // f5
        chk_out("restart_dead", 2'b11, 7'h7F, 1'b1);

        // Leading-zero tens digit
        load   = 1'b1;
        bcd_in = 8'h05;
        tick(); // f6
        load = 1'b0;
        tick(); // f7
`ifdef LEADING_ZERO_BLANK_EN
        chk_out("lz_tens", 2'b11, 7'h7F, 1'b1);
`else
        chk_out("lz_tens", 2'b01, 7'h40, 1'b1);
`endif
        tick(); tick(); tick(); // f8..f10
        tick(); // f11
        chk_out("lz_units", 2'b10, 7'h12, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
